// File: rtl/param_regfile_pkg.sv
// Shared types and default widths for the parametrised register file.
// Optional build feature: define PARAM_REGFILE_BYPASS_EN to forward same-edge
// write data onto a read port that addresses the register being written.
package param_regfile_pkg;

    // Sequencer states: CLEAR walks the array writing zeros, READY serves accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

endpackage : param_regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: owns the CLEAR/READY state and the address counter that
// sweeps every register to zero after reset or on request.
module regfile_clear_seq
    import param_regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // The last address of the array is all ones because DEPTH is 2**ADDR_W.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;

    // State and counter: sweep addresses in CLEAR, wait for a request in READY.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // A clear_req seen here is ignored: the sweep never restarts.
                    if (r_cnt == LAST_ADDR) begin
                        r_cnt   <= '0;
                        r_state <= READY;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (clear_req) begin
                        r_cnt   <= '0;
                        r_state <= CLEAR;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = r_cnt;

endmodule : regfile_clear_seq

// File: rtl/param_regfile.sv
// Parametrised 2-read/1-write register file with registered reads, a
// read-valid strobe, an optional hardwired zero register (ZERO_REG), a
// hardware clear sequencer and an access-rejected error pulse.
// Build option: PARAM_REGFILE_BYPASS_EN forwards same-edge write data to a
// read port addressing the written register; otherwise reads return old data.
module param_regfile
    import param_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic              rd_valid,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    output logic              error
);

    localparam int  DEPTH    = 2 ** ADDR_W;
    localparam bit  HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_data;
    logic [DATA_W-1:0] r_b_data;
    logic              r_rd_valid;
    logic              r_error;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clear_accept;
    logic              w_reject;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_wr_commit;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    // A clear request is only taken from READY; any access on that same edge,
    // or any access while the sweep runs, is rejected and flagged.
    assign w_clear_accept = clear_req & ~w_busy;
    assign w_reject       = (w_en | rd_en) & (w_busy | w_clear_accept);
    assign w_wr_ok        = w_en & ~w_reject;
    assign w_rd_ok        = rd_en & ~w_reject;
    // Writes to the hardwired zero register are dropped quietly, not flagged.
    assign w_wr_commit    = w_wr_ok & ~(HAS_ZERO && (w_addr == '0));

    // Read operand selection: array contents, optional forwarding, zero register.
    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_a_next = r_mem[a_addr];
        w_b_next = r_mem[b_addr];
`ifdef PARAM_REGFILE_BYPASS_EN
        if (w_wr_commit && (w_addr == a_addr)) begin
            w_a_next = w_data;
        end
        if (w_wr_commit && (w_addr == b_addr)) begin
            w_b_next = w_data;
        end
`endif
        if (HAS_ZERO && (a_addr == '0)) begin
            w_a_next = '0;
        end
        if (HAS_ZERO && (b_addr == '0)) begin
            w_b_next = '0;
        end
    end

    // Storage write port: the clear sweep always has priority over user writes.
    // NOTE: the array has no reset; the clear sequencer zeroes it after reset,
    // which keeps the storage free of per-bit reset wiring.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_commit) begin
            r_mem[w_addr] <= w_data;
        end
    end

    // Registered read data, read-valid strobe and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_data   <= '0;
            r_b_data   <= '0;
            r_rd_valid <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_error    <= w_reject;
            if (w_rd_ok) begin
                r_a_data <= w_a_next;
                r_b_data <= w_b_next;
            end
        end
    end

    assign busy     = w_busy;
    assign a_data   = r_a_data;
    assign b_data   = r_b_data;
    assign rd_valid = r_rd_valid;
    assign error    = r_error;

endmodule : param_regfile

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share the same stimulus; expectations follow the build macro
// PARAM_REGFILE_BYPASS_EN for same-edge read/write cases.
`timescale 1ns/1ps
module tb_param_regfile;

    logic        clk;
    logic        rst_n;
    logic        clear_req;
    logic [3:0]  a_addr, b_addr, w_addr;
    logic        rd_en, w_en;
    logic [15:0] w_data;

    logic        busy0, v0, e0;
    logic [15:0] a0, b0;
    logic        busy1, v1, e1;
    logic [15:0] a1, b1;

    int n_checks = 0;
    int n_err    = 0;

`ifdef PARAM_REGFILE_BYPASS_EN
    localparam logic [15:0] SAME_EDGE_R3 = 16'h2222;
    localparam logic [15:0] SAME_EDGE_R0 = 16'h5555;
`else
    localparam logic [15:0] SAME_EDGE_R3 = 16'h1111;
    localparam logic [15:0] SAME_EDGE_R0 = 16'hBEEF;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [3:0]  aa;
        logic [3:0]  ba;
        logic        ev;
        logic [15:0] ea0, eb0, ea1, eb1;
    } vec_t;

    vec_t vecs[$];

    param_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
        .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
        .a_data(a0), .b_data(b0), .rd_valid(v0),
        .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .error(e0)
    );

    param_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
        .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
        .a_data(a1), .b_data(b1), .rd_valid(v1),
        .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .error(e1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en      = 1'b0;
        rd_en     = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic read_both(input logic [3:0] aa, input logic [3:0] ba);
        a_addr = aa;
        b_addr = ba;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
    endtask

    // Count edges until busy falls; bounded so a stuck sequencer still ends.
    task automatic count_busy(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                                input logic re, input logic [3:0] aa, input logic [3:0] ba,
                                input logic ev, input logic [15:0] ea0, input logic [15:0] eb0,
                                input logic [15:0] ea1, input logic [15:0] eb1);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.aa = aa; v.ba = ba;
        v.ev = ev; v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1;
        return v;
    endfunction

    initial begin
        int n;
        int nb;

        // Vectors applied once registers 0..15 hold the values 0..15.
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(1'b0, 4'h0, 16'h0, 1'b1, 4'(i), 4'(15 - i), 1'b1,
                              16'(i), 16'(15 - i), 16'(i), 16'(15 - i)));
        end
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b0, 4'h0, 4'h0, 1'b0, 16'h000F, 16'h0000, 16'h000F, 16'h0000));
        vecs.push_back(mk(1'b1, 4'h0, 16'hBEEF, 1'b0, 4'h0, 4'h0, 1'b0, 16'h000F, 16'h0000, 16'h000F, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b1, 4'h0, 4'h5, 1'b1, 16'hBEEF, 16'h0005, 16'h0000, 16'h0005));
        vecs.push_back(mk(1'b1, 4'h5, 16'hBEEF, 1'b0, 4'h0, 4'h0, 1'b0, 16'hBEEF, 16'h0005, 16'h0000, 16'h0005));
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b1, 4'h5, 4'h0, 1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b1, 4'h5, 4'h5, 1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF));
        vecs.push_back(mk(1'b1, 4'h3, 16'h1111, 1'b0, 4'h0, 4'h0, 1'b0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF));
        vecs.push_back(mk(1'b1, 4'h3, 16'h2222, 1'b1, 4'h3, 4'h3, 1'b1, SAME_EDGE_R3, SAME_EDGE_R3, SAME_EDGE_R3, SAME_EDGE_R3));
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b1, 4'h3, 4'h0, 1'b1, 16'h2222, 16'hBEEF, 16'h2222, 16'h0000));
        vecs.push_back(mk(1'b1, 4'h0, 16'h5555, 1'b1, 4'h0, 4'h3, 1'b1, SAME_EDGE_R0, 16'h2222, 16'h0000, 16'h2222));
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b1, 4'h0, 4'h0, 1'b1, 16'h5555, 16'h5555, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 16'h0,    1'b1, 4'h7, 4'h5, 1'b1, 16'h0007, 16'hBEEF, 16'h0007, 16'hBEEF));

        // Reset state.
        rst_n  = 1'b0;
        idle();
        a_addr = '0; b_addr = '0; w_addr = '0; w_data = '0;
        #12;
        check("rst_busy", busy0, 1'b1);
        check("rst_a", a0, 16'h0);
        check("rst_b", b0, 16'h0);
        check("rst_valid", v0, 1'b0);
        check("rst_error", e0, 1'b0);
        rst_n = 1'b1;

        // Initial clear sweep length.
        count_busy(n);
        check("init_busy_edges", n, 16);
        check("init_busy1_low", busy1, 1'b0);

        // Every register reads zero after the sweep.
        for (int i = 0; i < 16; i++) begin
            read_both(4'(i), 4'(i));
            check("clr_read_valid", v0, 1'b1);
            check("clr_read_a", a0, 16'h0);
            check("clr_read_b", b0, 16'h0);
        end
        tick();
        check("valid_drops", v0, 1'b0);

        // Fill registers with their own index.
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; w_addr = 4'(i); w_data = 16'(i);
            tick();
        end
        idle();
        check("fill_no_error", e0, 1'b0);

        // Table-driven phase.
        foreach (vecs[k]) begin
            w_en = vecs[k].we; w_addr = vecs[k].wa; w_data = vecs[k].wd;
            rd_en = vecs[k].re; a_addr = vecs[k].aa; b_addr = vecs[k].ba;
            tick();
            check($sformatf("vec%0d_valid0", k), v0, vecs[k].ev);
            check($sformatf("vec%0d_valid1", k), v1, vecs[k].ev);
            check($sformatf("vec%0d_a0", k), a0, vecs[k].ea0);
            check($sformatf("vec%0d_b0", k), b0, vecs[k].eb0);
            check($sformatf("vec%0d_a1", k), a1, vecs[k].ea1);
            check($sformatf("vec%0d_b1", k), b1, vecs[k].eb1);
            check($sformatf("vec%0d_err0", k), e0, 1'b0);
            check($sformatf("vec%0d_err1", k), e1, 1'b0);
        end
        idle();

        // Clear request with a concurrent write: rejected, flagged, sweep starts.
        clear_req = 1'b1; w_en = 1'b1; w_addr = 4'h7; w_data = 16'h00AA;
        tick();
        idle();
        check("clrw_error0", e0, 1'b1);
        check("clrw_error1", e1, 1'b1);
        check("clrw_busy", busy0, 1'b1);
        check("clrw_valid", v0, 1'b0);
        check("clrw_a_hold", a0, 16'h0007);
        nb = 1;

        // Read during the sweep: rejected, data held, no valid.
        a_addr = 4'h5; b_addr = 4'h5; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rdbusy_error", e0, 1'b1);
        check("rdbusy_valid", v0, 1'b0);
        check("rdbusy_a_hold", a0, 16'h0007);
        if (busy0) nb++;
        tick();
        check("err_one_cycle", e0, 1'b0);
        if (busy0) nb++;
        while (busy0 === 1'b1 && nb < 40) begin
            tick();
            if (busy0) nb++;
        end
        check("req_busy_cycles", nb, 16);

        read_both(4'h7, 4'h5);
        check("reg7_cleared0", a0, 16'h0);
        check("reg5_cleared0", b0, 16'h0);
        check("reg7_cleared1", a1, 16'h0);
        check("clr_read_v", v0, 1'b1);

        // Reset in the middle of a sweep restarts it from zero.
        w_en = 1'b1; w_addr = 4'h5; w_data = 16'h1234;
        tick();
        idle();
        read_both(4'h5, 4'h5);
        check("pre_rst_a", a0, 16'h1234);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_busy", busy0, 1'b1);
        #2;
        rst_n = 1'b0;
        rd_en = 1'b1;
        #1;
        check("midrst_a", a0, 16'h0);
        check("midrst_b", b0, 16'h0);
        check("midrst_busy", busy0, 1'b1);
        tick();
        check("midrst_valid", v0, 1'b0);
        check("midrst_error", e0, 1'b0);
        rd_en = 1'b0;
        #3;
        rst_n = 1'b1;
        count_busy(n);
        check("midrst_busy_edges", n, 16);
        read_both(4'h5, 4'h0);
        check("post_midrst_a", a0, 16'h0);
        check("post_midrst_valid", v0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_param_regfile
